// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the FIR coefficient loader slice:
//     - default coefficient width and tap count
//     - loader FSM state encoding (legacy-compatible localparam constants)
//     - tap-address width helper
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int unsigned FIR_DEFAULT_DATA_WIDTH = 24;
  localparam int unsigned FIR_DEFAULT_DEPTH      = 16;

  // Loader FSM state encoding
  typedef logic [1:0] fir_state_t;

  localparam fir_state_t ST_IDLE   = 2'd0;
  localparam fir_state_t ST_LOAD   = 2'd1;
  localparam fir_state_t ST_CHECK  = 2'd2;
  localparam fir_state_t ST_COMMIT = 2'd3;

  // Tap index width; never below 1 so the port vectors stay legal.
  function automatic int unsigned fir_addr_width(input int unsigned depth);
    if (depth < 2) begin
      return 1;
    end
    return $clog2(depth);
  endfunction

endpackage : fir_pkg

// File: rtl/fir_coeff_checksum.sv
// -----------------------------------------------------------------------------
// fir_coeff_checksum
//   Running sum (mod 2^DATA_WIDTH) of the coefficients accepted during a frame
//   load, plus an equality compare against the trailing checksum word.
//   Present only when FIR_COEFF_CHECKSUM_EN is defined; without the macro the
//   loader has no checksum logic and this file contributes nothing.
//
// Ports
//   i_clk        in   clock
//   i_rst_n      in   asynchronous, active-low reset
//   i_clear      in   zero the running sum (frame start)
//   i_accum      in   add iv_data to the running sum
//   iv_data      in   coefficient being accepted
//   iv_expected  in   checksum word to compare against
//   o_match      out  running sum equals iv_expected
// -----------------------------------------------------------------------------
`ifdef FIR_COEFF_CHECKSUM_EN
module fir_coeff_checksum
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIR_DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_accum,
  input  logic [DATA_WIDTH-1:0] iv_data,
  input  logic [DATA_WIDTH-1:0] iv_expected,
  output logic                  o_match
);

  logic [DATA_WIDTH-1:0] sum;

  // Addition wraps naturally at DATA_WIDTH bits, giving the mod 2^N sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum <= '0;
    end else if (i_clear) begin
      sum <= '0;
    end else if (i_accum) begin
      sum <= sum + iv_data;
    end
  end

  assign o_match = (sum == iv_expected);

endmodule : fir_coeff_checksum
`endif

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//   Writer side of a two-bank FIR coefficient RAM. Accepts FIR_DEPTH
//   coefficients over valid/ready, writes them into the shadow bank and, after
//   a complete error-free frame, flips the active bank in a single cycle.
//
// Configuration
//   FIR_COEFF_CHECKSUM_EN  when defined, a trailing checksum word follows the
//                          taps; the bank flips only if it equals the running
//                          sum of the taps (mod 2^DATA_WIDTH).
//
// Ports
//   i_clk          in   clock
//   i_rst_n        in   asynchronous, active-low reset
//   i_start        in   begin a frame load (honoured in IDLE only)
//   i_abort        in   abandon the current load, no bank flip
//   iv_coeff       in   coefficient word
//   i_coeff_valid  in   iv_coeff valid
//   o_coeff_ready  out  loader accepts a word this cycle
//   o_we           out  coefficient RAM write strobe
//   ov_waddr       out  {bank, tap index}
//   ov_wdata       out  write data
//   o_active_bank  out  bank the filter reads from
//   o_busy         out  any state other than IDLE
//   o_done         out  1-cycle pulse when the bank flips
//   o_error        out  sticky error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FIR_DEFAULT_DATA_WIDTH,
  parameter  int unsigned FIR_DEPTH  = FIR_DEFAULT_DEPTH,
  localparam int unsigned ADDR_WIDTH = fir_addr_width(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] iv_coeff,
  input  logic                  i_coeff_valid,
  output logic                  o_coeff_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH:0]   ov_waddr,
  output logic [DATA_WIDTH-1:0] ov_wdata,
  output logic                  o_active_bank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(FIR_DEPTH - 1);

  fir_state_t            state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  accept;
  logic                  start_ok;

  assign o_coeff_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign o_busy        = (state != ST_IDLE);

  // An abort in the same cycle as a handshake discards the word.
  assign accept   = i_coeff_valid && o_coeff_ready && !i_abort;
  assign start_ok = (state == ST_IDLE) && i_start;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic sum_match;

  fir_coeff_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (start_ok),
    .i_accum     (accept && (state == ST_LOAD)),
    .iv_data     (iv_coeff),
    .iv_expected (iv_coeff),
    .o_match     (sum_match)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      o_we          <= 1'b0;
      ov_waddr      <= '0;
      ov_wdata      <= '0;
      o_active_bank <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            o_error <= 1'b0;
            count   <= '0;
            state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (i_abort) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (accept) begin
            o_we     <= 1'b1;
            ov_waddr <= {~o_active_bank, count};
            ov_wdata <= iv_coeff;
            // The counter stops at the last tap (never wraps); start clears it.
            if (count == LAST_TAP) begin
`ifdef FIR_COEFF_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_COMMIT;
`endif
            end else begin
              count <= count + ADDR_WIDTH'(1);
            end
          end
        end

`ifdef FIR_COEFF_CHECKSUM_EN
        ST_CHECK: begin
          if (i_abort) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (accept) begin
            // Trailer word is compared only, never written.
            if (sum_match) begin
              state <= ST_COMMIT;
            end else begin
              o_error <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
`endif

        ST_COMMIT: begin
          // One cycle here lets the final write land before the flip.
          o_active_bank <= ~o_active_bank;
          o_done        <= 1'b1;
          state         <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : fir_coeff_loader
